// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding,
// default operand widths and the iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } div_state_t;

    localparam int DEF_DIVIDEND_W = 16;
    localparam int DEF_DIVISOR_W  = 8;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_DIVIDEND_W);

endpackage

// File: rtl/abs_val.sv
// Conditional two's-complement negate. Driven by the operand sign bit it
// yields an unsigned magnitude; driven by a result sign it re-applies the sign.
module abs_val #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/seq_div.sv
// Sequential signed divider: restoring shift-subtract, one quotient bit per
// clock, C-style truncating semantics, start/done handshake.
module seq_div
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend_in,
    input  logic [DIVISOR_W-1:0]  divisor_in,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);

    div_state_t state, next_state;

    logic [DIVIDEND_W-1:0] dq;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W-1:0]  pr;
    logic [CNT_W-1:0]      count;
    logic                  sign_q;
    logic                  sign_r;
    logic                  zero_div;

    logic [DIVIDEND_W-1:0] dvd_mag_in;
    logic [DIVISOR_W-1:0]  dvs_mag_in;
    logic [DIVIDEND_W-1:0] q_signed;
    logic [DIVISOR_W-1:0]  r_signed;

    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W-1:0]  diff;
    logic                  no_borrow;

    abs_val #(.W(DIVIDEND_W)) u_abs_dividend (
        .value  (dividend_in),
        .negate (dividend_in[DIVIDEND_W-1]),
        .result (dvd_mag_in)
    );

    abs_val #(.W(DIVISOR_W)) u_abs_divisor (
        .value  (divisor_in),
        .negate (divisor_in[DIVISOR_W-1]),
        .result (dvs_mag_in)
    );

    abs_val #(.W(DIVIDEND_W)) u_fix_quotient (
        .value  (dq),
        .negate (sign_q),
        .result (q_signed)
    );

    abs_val #(.W(DIVISOR_W)) u_fix_remainder (
        .value  (pr),
        .negate (sign_r),
        .result (r_signed)
    );

    // The partial remainder stays below |divisor| <= 2^(DIVISOR_W-1), so a
    // successful trial subtraction always fits back into DIVISOR_W bits.
    assign shifted   = {pr, dq[DIVIDEND_W-1]};
    assign no_borrow = (shifted >= {1'b0, dvs});
    assign diff      = shifted[DIVISOR_W-1:0] - dvs;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                // A zero divisor skips the iteration loop entirely.
                if (start) begin
                    next_state = (divisor_in == '0) ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN: begin
                if (count == '0) begin
                    next_state = ST_FIX;
                end
            end
            ST_FIX:  next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            dq          <= '0;
            dvs         <= '0;
            pr          <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero_div    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dq          <= dvd_mag_in;
                        dvs         <= dvs_mag_in;
                        pr          <= '0;
                        count       <= CNT_W'(DIVIDEND_W - 1);
                        sign_q      <= dividend_in[DIVIDEND_W-1] ^ divisor_in[DIVISOR_W-1];
                        sign_r      <= dividend_in[DIVIDEND_W-1];
                        zero_div    <= (divisor_in == '0);
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    pr    <= no_borrow ? diff : shifted[DIVISOR_W-1:0];
                    dq    <= {dq[DIVIDEND_W-2:0], no_borrow};
                    count <= count - CNT_W'(1);
                end
                ST_FIX: begin
                    // Only -2^(N-1) / -1 yields a positive |q| of 2^(N-1).
                    if (zero_div) begin
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= q_signed;
                        remainder <= r_signed;
                        overflow  <= !sign_q && (dq == {1'b1, {(DIVIDEND_W-1){1'b0}}});
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed corner cases, handshake and reset
// behaviour, and randomized operands against a C-semantics reference model.
module tb_seq_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend_in;
    logic [7:0]  divisor_in;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    seq_div dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend_in (dividend_in),
        .divisor_in  (divisor_in),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer division, which truncates toward zero.
    function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                    output logic [15:0] q, output logic [7:0] r,
                                    output logic z, output logic o);
        int ai;
        int bi;
        int qi;
        int ri;
        ai = int'(signed'(a));
        bi = int'(signed'(b));
        if (bi == 0) begin
            q = 16'hFFFF;
            r = 8'h00;
            z = 1'b1;
            o = 1'b0;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            q  = qi[15:0];
            r  = ri[7:0];
            z  = 1'b0;
            o  = (qi > 32767);
        end
    endfunction

    // Issues one start and waits (bounded) for done; lat counts cycles after accept.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          output int lat, output bit busy_ok);
        bit seen;
        @(negedge clk);
        dividend_in = a;
        divisor_in  = b;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        seen    = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start       = 1'b0;
        dividend_in = 16'h0000;
        divisor_in  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b q=%h r=%h z=%b o=%b required all 0",
                     busy, done, quotient, remainder, div_by_zero, overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int          ta [8] = '{1000, -1000, 1000, -32768, -32768, -32768, 123, 10};
        int          tb [8] = '{7, 7, -7, -128, -1, 1, 0, 3};
        logic [15:0] tq [8] = '{16'h008E, 16'hFF72, 16'hFF72, 16'h0100, 16'h8000, 16'h8000, 16'hFFFF, 16'h0003};
        logic [7:0]  tr [8] = '{8'h06, 8'hFA, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        logic        tz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        to [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int          lat;
        int          exp_lat;
        bit          busy_ok;
        for (int i = 0; i < 8; i++) begin
            run_op(16'(ta[i]), 8'(tb[i]), lat, busy_ok);
            exp_lat = (tb[i] == 0) ? 2 : 18;
            checks++;
            if (lat != exp_lat || !busy_ok) begin
                errors++;
                $display("[TB] FAIL dir_timing[%0d]: got latency=%0d busy_ok=%0b required latency=%0d busy_ok=1",
                         i, lat, busy_ok, exp_lat);
            end
            checks++;
            if ({quotient, remainder, div_by_zero, overflow} !== {tq[i], tr[i], tz[i], to[i]}) begin
                errors++;
                $display("[TB] FAIL dir_result[%0d] %0d/%0d: got q=%h r=%h z=%b o=%b required q=%h r=%h z=%b o=%b",
                         i, ta[i], tb[i], quotient, remainder, div_by_zero, overflow, tq[i], tr[i], tz[i], to[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        bit busy_ok;
        bit seen;
        @(negedge clk);
        dividend_in = 16'd1000;
        divisor_in  = 8'd7;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        seen    = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 4) begin
                dividend_in = 16'd5;
                divisor_in  = 8'd1;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (lat != 18 || !busy_ok) begin
            errors++;
            $display("[TB] FAIL ignore_timing: got latency=%0d busy_ok=%0b required 18/1", lat, busy_ok);
        end
        checks++;
        if ({quotient, remainder} !== {16'h008E, 8'h06}) begin
            errors++;
            $display("[TB] FAIL ignore_result: got q=%h r=%h required q=008e r=06", quotient, remainder);
        end
        // Start raised during the DONE cycle only must not launch anything.
        start       = 1'b1;
        dividend_in = 16'd77;
        divisor_in  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse: got done=%b busy=%b after DONE required 0/0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || quotient !== 16'h008E) begin
            errors++;
            $display("[TB] FAIL start_in_done: got busy=%b q=%h required busy=0 q=008e", busy, quotient);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit busy_ok;
        int done_seen;
        @(negedge clk);
        dividend_in = 16'd1000;
        divisor_in  = 8'd7;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_op: got busy=%b done=%b q=%h r=%h z=%b o=%b required all 0",
                     busy, done, quotient, remainder, div_by_zero, overflow);
        end
        done_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("[TB] FAIL aborted_no_done: got %0d done cycles required 0", done_seen);
        end
        run_op(16'hFC18, 8'd7, lat, busy_ok);
        checks++;
        if (lat != 18 || {quotient, remainder} !== {16'hFF72, 8'hFA}) begin
            errors++;
            $display("[TB] FAIL fresh_after_reset: got latency=%0d q=%h r=%h required 18 ff72 fa",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back_random(input int n);
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        logic        eo;
        int          lat;
        int          exp_lat;
        bit          busy_ok;
        int          sel;
        for (int i = 0; i < n; i++) begin
            a   = 16'($urandom);
            b   = 8'($urandom);
            sel = int'($urandom_range(0, 11));
            if (sel == 0) b = 8'h00;
            if (sel == 1) b = 8'hFF;
            if (sel == 2) b = 8'h80;
            if (sel == 3 || sel == 1) a = 16'h8000;
            ref_div(a, b, eq, er, ez, eo);
            exp_lat = (b == 8'h00) ? 2 : 18;
            run_op(a, b, lat, busy_ok);
            checks++;
            if (lat != exp_lat || !busy_ok) begin
                errors++;
                $display("[TB] FAIL rand_timing[%0d] a=%h b=%h: got latency=%0d busy_ok=%0b required %0d/1",
                         i, a, b, lat, busy_ok, exp_lat);
            end
            checks++;
            if ({quotient, remainder, div_by_zero, overflow} !== {eq, er, ez, eo}) begin
                errors++;
                $display("[TB] FAIL rand_result[%0d] a=%h b=%h: got q=%h r=%h z=%b o=%b required q=%h r=%h z=%b o=%b",
                         i, a, b, quotient, remainder, div_by_zero, overflow, eq, er, ez, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_op();
        test_back_to_back_random(2000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
